// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - Bin one bit per clock, LSB first.
// Diff/Bout are updated only at the completion edge, which is flagged by done.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             br;
    logic             bit_a;
    logic             bit_b;
    logic             bit_d;
    logic             br_nx;
    logic             last;
    logic [WIDTH-1:0] d_full;

    assign bit_a  = a_sr[0];
    assign bit_b  = b_sr[0];
    assign bit_d  = bit_a ^ bit_b ^ br;
    assign br_nx  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign d_full = {bit_d, d_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath; the result registers are written only on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            br   <= 1'b0;
            Diff <= '0;
            Bout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= '0;
                        a_sr <= A;
                        b_sr <= B;
                        d_sr <= '0;
                        br   <= Bin;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    d_sr <= d_full;
                    br   <= br_nx;
                    if (last) begin
                        Diff <= d_full;
                        Bout <= br_nx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: transaction-level model checked every cycle,
// plus directed operand cases with hand-computed results.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Bout;

    int total = 0;
    int passed = 0;
    int cyc = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: an accepted operation stays busy for W+1 cycles, its
    // result appears W edges after acceptance, done marks that one cycle.
    logic         m_active;
    int           m_age;
    logic [W-1:0] m_diff;
    logic         m_bout;
    logic [W-1:0] p_diff;
    logic         p_bout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_diff   <= '0;
            m_bout   <= 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_age    <= 0;
                p_diff   <= W'(int'(A) - int'(B) - int'(Bin));
                p_bout   <= (int'(A) < int'(B) + int'(Bin));
            end
        end else if (m_age == W) begin
            m_active <= 1'b0;
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == W) begin
                m_diff <= p_diff;
                m_bout <= p_bout;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", int'(busy), int'(m_active));
        check("done", int'(done), int'(m_active && m_age == W));
        check("diff", int'(Diff), int'(m_diff));
        check("bout", int'(Bout), int'(m_bout));
    end

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    task automatic run_op(input int a, input int b, input int bi,
                          input int ed, input int eb);
        int lat;
        @(posedge clk);
        #2;
        start = 1'b1;
        A = W'(a);
        B = W'(b);
        Bin = 1'(bi);
        @(posedge clk);
        #2;
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        Bin = 1'($urandom);
        wait_done(lat);
        check("latency", lat, W);
        check("diff_lit", int'(Diff), ed);
        check("bout_lit", int'(Bout), eb);
    endtask

    task automatic count_done(input int n, output int cnt, output int d,
                              output int bo);
        cnt = 0;
        d = -1;
        bo = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                d = int'(Diff);
                bo = int'(Bout);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int d;
        int bo;
        int t[3];
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        Bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_diff", int'(Diff), 0);
        #1;
        rst_n = 1'b1;

        run_op(7, 15, 0, 8, 1);
        run_op(15, 0, 0, 15, 0);
        run_op(15, 0, 1, 14, 0);
        run_op(0, 0, 1, 15, 1);
        run_op(9, 9, 0, 0, 0);

        // restart attempt while busy must be ignored
        @(posedge clk);
        #2;
        start = 1'b1;
        A = 4'd7;
        B = 4'd15;
        Bin = 1'b0;
        @(posedge clk);
        #2;
        start = 1'b0;
        A = 4'd3;
        @(posedge clk);
        #2;
        start = 1'b1;
        A = 4'd1;
        B = 4'd1;
        @(posedge clk);
        #2;
        start = 1'b0;
        A = 4'd5;
        B = 4'd2;
        count_done(10, n, d, bo);
        check("ign_dones", n, 1);
        check("ign_diff", d, 8);
        check("ign_bout", bo, 1);

        // reset mid-operation aborts it
        @(posedge clk);
        #2;
        start = 1'b1;
        A = 4'd9;
        B = 4'd2;
        @(posedge clk);
        #2;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_diff", int'(Diff), 0);
        check("abort_bout", int'(Bout), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        count_done(10, n, d, bo);
        check("abort_dones", n, 0);
        run_op(9, 2, 0, 7, 0);

        // start held high: back-to-back operations
        @(posedge clk);
        #2;
        start = 1'b1;
        n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            @(negedge clk);
            if (done) begin
                t[n] = cyc;
                n++;
            end
            @(posedge clk);
            #2;
            A = W'($urandom);
            B = W'($urandom);
            Bin = 1'($urandom);
        end
        start = 1'b0;
        check("b2b_count", n, 3);
        check("b2b_gap1", t[1] - t[0], W + 2);
        check("b2b_gap2", t[2] - t[1], W + 2);

        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #2;
            start = ($urandom_range(0, 2) == 0);
            A = W'($urandom);
            B = W'($urandom);
            Bin = 1'($urandom);
        end
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits; legal range 2..16.
REQ-002 The block SHALL use a single clock clk and an asynchronous, active-low reset rst_n.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-006 Port: A  input  WIDTH  minuend; sampled only on the accepting edge.
REQ-007 Port: B  input  WIDTH  subtrahend; sampled only on the accepting edge.
REQ-008 Port: Bin  input  1  borrow-in; sampled only on the accepting edge.
REQ-009 Port: busy  output  1  high while an operation is in progress (SHIFT or DONE state).
REQ-010 Port: done  output  1  one-cycle pulse that marks Diff/Bout as newly updated.
REQ-011 Port: Diff  output  WIDTH  registered result, (A - B - Bin) mod 2^WIDTH.
REQ-012 Port: Bout  output  1  registered borrow-out; 1 iff A < B + Bin (unsigned).

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 IDLE: when start=1 at a rising edge (edge N), the block SHALL:
  - capture A, B and Bin into internal shift and borrow registers;
  - clear the bit counter;
  - go to SHIFT.
REQ-015 SHIFT: on each of edges N+1..N+WIDTH, the block SHALL process the LSB of the A/B shift registers:
  - d = a ^ b ^ br;
  - br_next = (~a & b) | (~(a ^ b) & br);
  - shift the A/B registers right;
  - shift d into the MSB of the internal difference register.
REQ-016 At edge N+WIDTH, the block SHALL load Diff and Bout from the completed internal difference and borrow registers and go to DONE.
REQ-017 DONE: done=1 for exactly the cycle between edges N+WIDTH and N+WIDTH+1; at edge N+WIDTH+1 the FSM SHALL go to IDLE.
REQ-018 Latency from the accepting edge to done high SHALL be exactly WIDTH cycles; throughput SHALL be one operation per WIDTH+2 cycles.
REQ-019 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-020 start SHALL be ignored in SHIFT and DONE, with no effect on the current operation.
REQ-021 A, B and Bin changing after the accepting edge SHALL NOT affect the current result.
REQ-022 Diff and Bout SHALL hold their last value at all times except at the completion edge; intermediate bits SHALL never appear on Diff.
REQ-023 start held high continuously SHALL give back-to-back operations: a new operation is accepted on the first edge in IDLE after each DONE.
REQ-024 The bit counter SHALL span 0..WIDTH-1 with no wrap-around beyond the WIDTH steps.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately set:
  - FSM to IDLE;
  - busy=0, done=0, Diff=0, Bout=0;
  - counter, shift registers and borrow register to 0.
REQ-026 A reset asserted mid-operation SHALL abort the operation; no done pulse and no result update SHALL follow.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=4)
REQ-028 A=7, B=15, Bin=0, pulse start -> done 4 cycles later; Diff=8, Bout=1.
REQ-029 A=15, B=0, Bin=0 -> Diff=15, Bout=0; then A=15, B=0, Bin=1 -> Diff=14, Bout=0.
REQ-030 A=0, B=0, Bin=1 (borrow wrap) -> Diff=15, Bout=1; A=9, B=9, Bin=0 -> Diff=0, Bout=0.
REQ-031 Start A=7, B=15; pulse start again with A=1, B=1 on cycle 2 and change A/B inputs -> single done; Diff=8, Bout=1; second start ignored.
REQ-032 Start an operation; assert rst_n=0 on cycle 2 -> busy, done, Diff and Bout all 0 immediately; no done pulse afterwards.
REQ-033 Hold start=1 for three operations -> done pulses exactly 6 cycles apart, each with the correct Diff/Bout for the operands sampled at its accepting edge.
